// File: rtl/multi_pulse_tracer.sv
// Multi-channel glitch filter and edge-event detector: per-channel synchroniser,
// consecutive-sample debounce, mode-qualified one-cycle pulses and saturating event counters.
module multi_pulse_tracer #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned FILTER_LEN = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       noisy_in,
    input  logic [1:0]                mode,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       level_out,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic                      any_pulse,
    output logic [CHANNELS*CNT_W-1:0] event_cnt
);

    localparam int unsigned      RUN_W    = $clog2(FILTER_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_sel_e;

    edge_sel_e mode_sel;

    logic [CHANNELS-1:0] s1_q;
    logic [CHANNELS-1:0] s2_q;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] pulse_q;
    logic [CHANNELS-1:0] pulse_d;
    logic [CHANNELS-1:0] rise_ev;
    logic [CHANNELS-1:0] fall_ev;
    logic                any_q;
    logic [RUN_W-1:0]    run_q [CHANNELS];
    logic [RUN_W-1:0]    run_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    assign mode_sel = edge_sel_e'(mode);

    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        rise_ev = '0;
        fall_ev = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            run_d[i] = run_q[i];
            cnt_d[i] = cnt_q[i];
            // A sample matching the current level breaks the streak entirely.
            if (s2_q[i] == level_q[i]) begin
                run_d[i] = '0;
            end else if (run_q[i] == RUN_LAST) begin
                run_d[i]   = '0;
                level_d[i] = s2_q[i];
                rise_ev[i] = s2_q[i];
                fall_ev[i] = ~s2_q[i];
            end else begin
                run_d[i] = run_q[i] + RUN_W'(1);
            end

            pulse_d[i] = (rise_ev[i] && (mode_sel == EDGE_RISE || mode_sel == EDGE_BOTH)) ||
                         (fall_ev[i] && (mode_sel == EDGE_FALL || mode_sel == EDGE_BOTH));

            // A clear coincident with a pulse keeps that pulse's count.
            if (cnt_clr) begin
                cnt_d[i] = pulse_d[i] ? CNT_W'(1) : '0;
            end else if (pulse_d[i] && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                run_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= noisy_in;
            s2_q    <= s1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            any_q   <= |pulse_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                run_q[i] <= run_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_out = level_q;
    assign pulse_out = pulse_q;
    assign any_pulse = any_q;

    always_comb begin
        event_cnt = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            event_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_multi_pulse_tracer.sv
// Bench for multi_pulse_tracer: directed scenarios plus randomized traffic against a
// sample-window reference model; a second instance with 2-bit counters covers saturation.
module tb_multi_pulse_tracer;

    localparam int CH = 4;
    localparam int FL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  noisy = '0;
    logic [1:0]  mode = 2'b00;
    logic        cnt_clr = 1'b0;

    logic [3:0]  level_out, pulse_out, level2, pulse2;
    logic        any_pulse, any2;
    logic [31:0] event_cnt;
    logic [7:0]  event_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          lvl_m [CH];
    bit          pls_m [CH];
    int unsigned c8_m  [CH];
    int unsigned c2_m  [CH];
    bit          any_m;
    bit          samp_q [CH][$];

    always #5 clk = ~clk;

    multi_pulse_tracer #(.CHANNELS(4), .FILTER_LEN(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .noisy_in(noisy), .mode(mode), .cnt_clr(cnt_clr),
        .level_out(level_out), .pulse_out(pulse_out), .any_pulse(any_pulse),
        .event_cnt(event_cnt)
    );

    multi_pulse_tracer #(.CHANNELS(4), .FILTER_LEN(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .noisy_in(noisy), .mode(mode), .cnt_clr(cnt_clr),
        .level_out(level2), .pulse_out(pulse2), .any_pulse(any2),
        .event_cnt(event_cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            lvl_m[i] = 1'b0;
            pls_m[i] = 1'b0;
            c8_m[i]  = 0;
            c2_m[i]  = 0;
            samp_q[i].delete();
            // The two synchroniser stages hold 0 coming out of reset.
            samp_q[i].push_back(1'b0);
            samp_q[i].push_back(1'b0);
        end
        any_m = 1'b0;
    endfunction

    // Level flips once the last FL samples seen by the filter all differ from it;
    // the sample seen at an edge is the input captured two edges earlier.
    function automatic void model_step();
        any_m = 1'b0;
        for (int i = 0; i < CH; i++) begin
            int  n;
            bit  flip;
            bit  qual;
            samp_q[i].push_back(noisy[i]);
            n    = samp_q[i].size();
            flip = 1'b1;
            for (int j = 0; j < FL; j++) begin
                int idx = n - 3 - j;
                if (idx < 0) flip = 1'b0;
                else if (samp_q[i][idx] == lvl_m[i]) flip = 1'b0;
            end
            qual = 1'b0;
            if (flip) begin
                lvl_m[i] = ~lvl_m[i];
                if (lvl_m[i]) qual = (mode == 2'd0 || mode == 2'd2);
                else          qual = (mode == 2'd1 || mode == 2'd2);
            end
            pls_m[i] = qual;
            if (cnt_clr) begin
                c8_m[i] = qual ? 1 : 0;
                c2_m[i] = qual ? 1 : 0;
            end else if (qual) begin
                if (c8_m[i] < 255) c8_m[i]++;
                if (c2_m[i] < 3)   c2_m[i]++;
            end
            any_m = any_m | qual;
            while (samp_q[i].size() > 32) void'(samp_q[i].pop_front());
        end
    endfunction

    task automatic check_all();
        logic [3:0]  el, ep;
        logic [31:0] e8;
        logic [7:0]  e2;
        for (int i = 0; i < CH; i++) begin
            el[i] = lvl_m[i];
            ep[i] = pls_m[i];
            e8[i*8 +: 8] = 8'(c8_m[i]);
            e2[i*2 +: 2] = 2'(c2_m[i]);
        end
        check_eq("level", 32'(level_out), 32'(el));
        check_eq("pulse", 32'(pulse_out), 32'(ep));
        check_eq("any_pulse", 32'(any_pulse), 32'(any_m));
        check_eq("event_cnt", event_cnt, e8);
        check_eq("pulse_sat", 32'(pulse2), 32'(ep));
        check_eq("event_cnt_sat", 32'(event_cnt2), 32'(e2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int hold [CH];

    initial begin
        model_reset();
        #1;
        check_eq("reset_level", 32'(level_out), 32'd0);
        check_eq("reset_cnt", event_cnt, 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(4);

        // Short glitch: two captures only
        noisy[0] = 1'b1; ticks(2);
        noisy[0] = 1'b0; ticks(8);
        check_eq("glitch_level", 32'(level_out[0]), 32'd0);
        check_eq("glitch_cnt", 32'(event_cnt[7:0]), 32'd0);

        // Valid rise: pulse exactly after the fifth edge from first capture
        noisy[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq("rise_pulse_timing", 32'(pulse_out[0]), (k == 5) ? 32'd1 : 32'd0);
        end
        check_eq("rise_level", 32'(level_out[0]), 32'd1);
        ticks(10);
        check_eq("rise_hold_cnt", 32'(event_cnt[7:0]), 32'd1);

        // Both edges, then fall-only, then disabled
        mode = 2'b10;
        noisy[1] = 1'b1; ticks(5); noisy[1] = 1'b0; ticks(5); ticks(5);
        check_eq("both_cnt", 32'(event_cnt[15:8]), 32'd2);
        mode = 2'b01;
        noisy[1] = 1'b1; ticks(5); noisy[1] = 1'b0; ticks(10);
        check_eq("fall_cnt", 32'(event_cnt[15:8]), 32'd3);
        mode = 2'b11;
        noisy[1] = 1'b1; ticks(6);
        check_eq("off_level", 32'(level_out[1]), 32'd1);
        noisy[1] = 1'b0; ticks(6);
        check_eq("off_cnt", 32'(event_cnt[15:8]), 32'd3);
        mode = 2'b00;

        // Streak break on ch2
        noisy[2] = 1'b1; ticks(2);
        noisy[2] = 1'b0; tick();
        noisy[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq("streak_pulse", 32'(pulse_out[2]), (k == 5) ? 32'd1 : 32'd0);
            check_eq("streak_any", 32'(any_pulse), (k == 5) ? 32'd1 : 32'd0);
        end
        check_eq("streak_cnt", 32'(event_cnt[23:16]), 32'd1);

        // Saturation on the 2-bit instance, ch3
        for (int r = 0; r < 5; r++) begin
            noisy[3] = 1'b1; ticks(4);
            noisy[3] = 1'b0; ticks(4);
        end
        check_eq("sat_cnt2", 32'(event_cnt2[7:6]), 32'd3);
        check_eq("sat_cnt8", 32'(event_cnt[31:24]), 32'd5);
        noisy[3] = 1'b1; ticks(4);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check_eq("clr_with_pulse", 32'(event_cnt[31:24]), 32'd1);
        check_eq("clr_with_pulse_sat", 32'(event_cnt2[7:6]), 32'd1);
        check_eq("clr_other_ch", 32'(event_cnt[7:0]), 32'd0);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        check_eq("clr_alone", event_cnt, 32'd0);

        // Parallel rises on ch0 and ch2
        noisy[0] = 1'b0; noisy[2] = 1'b0; ticks(8);
        noisy[0] = 1'b1; noisy[2] = 1'b1; ticks(5);
        check_eq("par_pulse", 32'(pulse_out & 4'b0101), 32'h5);
        check_eq("par_any", 32'(any_pulse), 32'd1);
        tick();
        check_eq("par_any_drop", 32'(any_pulse), 32'd0);

        // Reset mid-streak on ch1
        noisy[1] = 1'b1; ticks(2);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_async_level", 32'(level_out), 32'd0);
        check_eq("rst_async_cnt", event_cnt, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq("rst_restart_pulse", 32'(pulse_out[1]), (k == 5) ? 32'd1 : 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < CH; i++) hold[i] = $urandom_range(1, 6);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if (hold[i] == 0) begin
                    noisy[i] = ~noisy[i];
                    hold[i]  = $urandom_range(1, 6);
                end
                hold[i]--;
            end
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            cnt_clr = ($urandom_range(0, 59) == 0);
            rst     = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0;
        cnt_clr = 1'b0;
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
